// File: rtl/sdram_arb_pkg.sv
// Shared types and widths for the SDRAM arbiter between the video reader and the loader writer.
package sdram_arb_pkg;

    localparam int SD_ADDR_W = 25;
    localparam int SD_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        VID_BURST = 2'd1,
        VID_DRAIN = 2'd2,
        WR_WAIT   = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic [SD_ADDR_W-1:0] addr;
        logic [SD_DATA_W-1:0] data;
    } wr_entry_t;

endpackage

// File: rtl/arb_write_fifo.sv
// Synchronous loader write FIFO with registered full/empty flags.
// A push arriving while full is accepted only when a pop happens in the same cycle.
module arb_write_fifo
    import sdram_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk_sys_99_287,
    input  logic      reset,
    input  logic      push,
    input  wr_entry_t push_data,
    input  logic      pop,
    output wr_entry_t pop_data,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [AW-1:0] PTR_ONE   = AW'(1'b1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1'b1);
    localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

    wr_entry_t       mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic [CW-1:0]   count_s;
    logic            full_r;
    logic            empty_r;
    logic            push_ok_s;
    logic            pop_ok_s;

    // Qualify push/pop against the current flags and compute the next occupancy.
    always_comb begin
        pop_ok_s  = pop & ~empty_r;
        push_ok_s = push & (~full_r | pop_ok_s);
        count_s   = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_s = count_r + CNT_ONE;
            2'b01:   count_s = count_r - CNT_ONE;
            default: count_s = count_r;
        endcase
    end

    // Pointer, occupancy and flag registers.
    always_ff @(posedge clk_sys_99_287) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_s;
            full_r  <= (count_s == CNT_DEPTH);
            empty_r <= (count_s == {CW{1'b0}});
        end
    end

    // Storage array; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clk_sys_99_287) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign pop_data = mem_r[rd_ptr_r];
    assign full     = full_r;
    assign empty    = empty_r;

endmodule

// File: rtl/sdram_arbiter.sv
// SDRAM arbiter: video burst reads take strict priority over queued loader writes.
// Optional wait-cycle counter on perf_vid_wait is built when SDRAM_ARB_PERF_EN is defined.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int WR_FIFO_DEPTH = 4,
    parameter int PERF_W        = 16
) (
    input  logic                 clk_sys_99_287,
    input  logic                 reset,
    input  logic                 vid_rd,
    input  logic [SD_ADDR_W-1:0] vid_rd_addr,
    input  logic                 vid_end_burst,
    output logic                 vid_data_available,
    output logic [SD_DATA_W-1:0] vid_data,
    input  logic                 ld_wr,
    input  logic [SD_ADDR_W-1:0] ld_wr_addr,
    input  logic [SD_DATA_W-1:0] ld_wr_data,
    output logic                 ld_busy,
    input  logic                 sd_ready,
    input  logic                 sd_data_available,
    input  logic [SD_DATA_W-1:0] sd_out,
    output logic                 sd_rd,
    output logic                 sd_wr,
    output logic [SD_ADDR_W-1:0] sd_addr,
    output logic [SD_DATA_W-1:0] sd_wr_data,
    output logic                 sd_end_burst,
    output logic [PERF_W-1:0]    perf_vid_wait
);

    arb_state_t           state_r;
    arb_state_t           state_s;
    logic                 vid_pend_r;
    logic [SD_ADDR_W-1:0] vid_pend_addr_r;
    logic                 vid_req_s;
    logic [SD_ADDR_W-1:0] vid_req_addr_s;
    logic                 issue_vid_s;
    logic                 pop_s;
    logic                 sd_rd_s;
    logic                 sd_wr_s;
    logic                 sd_end_burst_s;
    logic [SD_ADDR_W-1:0] sd_addr_s;
    logic [SD_DATA_W-1:0] sd_wr_data_s;
    logic                 fwd_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    wr_entry_t            fifo_head_s;
    wr_entry_t            push_entry_s;

    logic                 sd_rd_r;
    logic                 sd_wr_r;
    logic                 sd_end_burst_r;
    logic [SD_ADDR_W-1:0] sd_addr_r;
    logic [SD_DATA_W-1:0] sd_wr_data_r;
    logic                 vid_avail_r;
    logic [SD_DATA_W-1:0] vid_data_r;

    assign push_entry_s = '{addr: ld_wr_addr, data: ld_wr_data};

    arb_write_fifo #(
        .DEPTH (WR_FIFO_DEPTH)
    ) u_wr_fifo (
        .clk_sys_99_287 (clk_sys_99_287),
        .reset          (reset),
        .push           (ld_wr),
        .push_data      (push_entry_s),
        .pop            (pop_s),
        .pop_data       (fifo_head_s),
        .full           (fifo_full_s),
        .empty          (fifo_empty_s)
    );

    // A fresh vid_rd is eligible in the same cycle so an idle arbiter issues with one cycle of latency.
    always_comb begin
        vid_req_s = vid_pend_r | vid_rd;
        if (vid_pend_r) begin
            vid_req_addr_s = vid_pend_addr_r;
        end else begin
            vid_req_addr_s = vid_rd_addr;
        end
        fwd_s = (state_r == VID_BURST) || (state_r == VID_DRAIN);
    end

    // Next-state and command decode; video wins over a pending write.
    always_comb begin
        state_s        = state_r;
        issue_vid_s    = 1'b0;
        pop_s          = 1'b0;
        sd_rd_s        = 1'b0;
        sd_wr_s        = 1'b0;
        sd_end_burst_s = 1'b0;
        sd_addr_s      = {SD_ADDR_W{1'b0}};
        sd_wr_data_s   = {SD_DATA_W{1'b0}};
        case (state_r)
            IDLE: begin
                if (sd_ready && vid_req_s) begin
                    issue_vid_s = 1'b1;
                    sd_rd_s     = 1'b1;
                    sd_addr_s   = vid_req_addr_s;
                    state_s     = VID_BURST;
                end else if (sd_ready && !fifo_empty_s) begin
                    pop_s        = 1'b1;
                    sd_wr_s      = 1'b1;
                    sd_addr_s    = fifo_head_s.addr;
                    sd_wr_data_s = fifo_head_s.data;
                    state_s      = WR_WAIT;
                end else begin
                    state_s = IDLE;
                end
            end
            VID_BURST: begin
                if (vid_end_burst) begin
                    sd_end_burst_s = 1'b1;
                    state_s        = VID_DRAIN;
                end else begin
                    state_s = VID_BURST;
                end
            end
            VID_DRAIN, WR_WAIT: begin
                if (sd_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_sys_99_287) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Video pending latch: first vid_rd is held until issued, later ones are ignored.
    always_ff @(posedge clk_sys_99_287) begin
        if (reset) begin
            vid_pend_r      <= 1'b0;
            vid_pend_addr_r <= {SD_ADDR_W{1'b0}};
        end else if (issue_vid_s) begin
            vid_pend_r <= 1'b0;
        end else if (vid_rd && !vid_pend_r) begin
            vid_pend_r      <= 1'b1;
            vid_pend_addr_r <= vid_rd_addr;
        end
    end

    // Registered SDRAM commands and the one-cycle read-data forward path.
    always_ff @(posedge clk_sys_99_287) begin
        if (reset) begin
            sd_rd_r        <= 1'b0;
            sd_wr_r        <= 1'b0;
            sd_end_burst_r <= 1'b0;
            sd_addr_r      <= {SD_ADDR_W{1'b0}};
            sd_wr_data_r   <= {SD_DATA_W{1'b0}};
            vid_avail_r    <= 1'b0;
            vid_data_r     <= {SD_DATA_W{1'b0}};
        end else begin
            sd_rd_r        <= sd_rd_s;
            sd_wr_r        <= sd_wr_s;
            sd_end_burst_r <= sd_end_burst_s;
            sd_addr_r      <= sd_addr_s;
            sd_wr_data_r   <= sd_wr_data_s;
            vid_avail_r    <= sd_data_available & fwd_s;
            vid_data_r     <= fwd_s ? sd_out : {SD_DATA_W{1'b0}};
        end
    end

`ifdef SDRAM_ARB_PERF_EN
    logic [PERF_W-1:0] perf_cnt_r;

    // Saturating count of cycles a latched video request sat without being issued.
    always_ff @(posedge clk_sys_99_287) begin
        if (reset) begin
            perf_cnt_r <= {PERF_W{1'b0}};
        end else if (vid_pend_r && !issue_vid_s && (perf_cnt_r != {PERF_W{1'b1}})) begin
            perf_cnt_r <= perf_cnt_r + PERF_W'(1'b1);
        end
    end

    assign perf_vid_wait = perf_cnt_r;
`else
    assign perf_vid_wait = {PERF_W{1'b0}};
`endif

    assign sd_rd              = sd_rd_r;
    assign sd_wr              = sd_wr_r;
    assign sd_end_burst       = sd_end_burst_r;
    assign sd_addr            = sd_addr_r;
    assign sd_wr_data         = sd_wr_data_r;
    assign vid_data_available = vid_avail_r;
    assign vid_data           = vid_data_r;
    assign ld_busy            = fifo_full_s;

endmodule
